// File: rtl/not_pipe_pkg.sv
// Shared constants and types for the not_pipe masked-invert pipeline.
// Parity support is enabled by defining NOT_PIPE_PARITY_EN.
package not_pipe_pkg;

    localparam int DEPTH_MAX = 16;

    // Width of the occupancy counter for a given stage count.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Per-stage control bits; the data word is width-dependent and is
    // attached by the stage module, which knows WIDTH.
    typedef struct packed {
        logic valid;
`ifdef NOT_PIPE_PARITY_EN
        logic par;
`endif
    } stage_ctl_t;

endpackage

// File: rtl/not_pipe_stage.sv
// One register slice of the not_pipe pipeline: valid, data and optional parity.
// Parity bit present only when NOT_PIPE_PARITY_EN is defined.
module not_pipe_stage
    import not_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
`ifdef NOT_PIPE_PARITY_EN
    input  logic             in_par,
    output logic             par,
`endif
    input  logic             load,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    typedef struct packed {
        stage_ctl_t       ctl;
        logic [WIDTH-1:0] data;
    } stage_t;

    stage_t stage_q;
    stage_t stage_d;

    // Payload only moves with a real beat so Y holds its last value when empty.
    always_comb begin
        stage_d = stage_q;
        if (load) begin
            stage_d.ctl.valid = in_valid;
            if (in_valid) begin
                stage_d.data    = in_data;
`ifdef NOT_PIPE_PARITY_EN
                stage_d.ctl.par = in_par;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign valid = stage_q.ctl.valid;
    assign data  = stage_q.data;
`ifdef NOT_PIPE_PARITY_EN
    assign par   = stage_q.ctl.par;
`endif

endmodule

// File: rtl/not_pipe.sv
// Pipelined masked inverter: Y = A ^ MASK carried through DEPTH valid/ready stages.
// Define NOT_PIPE_PARITY_EN to add the Y_PAR output.
module not_pipe
    import not_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [WIDTH-1:0]          A,
    input  logic [WIDTH-1:0]          MASK,
    input  logic                      A_VALID,
    output logic                      A_READY,
    output logic [WIDTH-1:0]          Y,
    output logic                      Y_VALID,
    input  logic                      Y_READY,
`ifdef NOT_PIPE_PARITY_EN
    output logic                      Y_PAR,
`endif
    output logic [occ_w(DEPTH)-1:0]   OCC
);

    localparam int OCC_W = occ_w(DEPTH);

    generate
        if (DEPTH < 1 || DEPTH > DEPTH_MAX) begin : g_bad_depth
            $error("not_pipe: DEPTH must be in 1..16");
        end
        if (WIDTH < 1) begin : g_bad_width
            $error("not_pipe: WIDTH must be at least 1");
        end
    endgenerate

    logic             stg_valid [DEPTH];
    logic [WIDTH-1:0] stg_data  [DEPTH];
`ifdef NOT_PIPE_PARITY_EN
    logic             stg_par   [DEPTH];
`endif
    logic [DEPTH:0]   ld;
    logic [WIDTH-1:0] in_word;
    logic             accept;
    logic             drain;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;

    // Gate by A_VALID so an undriven A/MASK never reaches a stage register.
    assign in_word = A_VALID ? (A ^ MASK) : '0;

    // Ready chain: an empty stage always loads, so bubbles collapse.
    always_comb begin
        ld        = '0;
        ld[DEPTH] = Y_READY;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            ld[i] = !stg_valid[i] || ld[i+1];
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic             s_in_valid;
            logic [WIDTH-1:0] s_in_data;
`ifdef NOT_PIPE_PARITY_EN
            logic             s_in_par;
`endif
            if (gi == 0) begin : g_head
                assign s_in_valid = A_VALID;
                assign s_in_data  = in_word;
`ifdef NOT_PIPE_PARITY_EN
                assign s_in_par   = ^in_word;
`endif
            end else begin : g_body
                assign s_in_valid = stg_valid[gi-1];
                assign s_in_data  = stg_data[gi-1];
`ifdef NOT_PIPE_PARITY_EN
                assign s_in_par   = stg_par[gi-1];
`endif
            end

            not_pipe_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk      (CLK),
                .rst_n    (RST_N),
                .in_valid (s_in_valid),
                .in_data  (s_in_data),
`ifdef NOT_PIPE_PARITY_EN
                .in_par   (s_in_par),
                .par      (stg_par[gi]),
`endif
                .load     (ld[gi]),
                .valid    (stg_valid[gi]),
                .data     (stg_data[gi])
            );
        end
    endgenerate

    assign A_READY = ld[0];
    assign Y       = stg_data[DEPTH-1];
    assign Y_VALID = stg_valid[DEPTH-1];
`ifdef NOT_PIPE_PARITY_EN
    assign Y_PAR   = stg_par[DEPTH-1];
`endif

    assign accept = A_VALID && A_READY;
    assign drain  = Y_VALID && Y_READY;

    always_comb begin
        occ_d = occ_q;
        if (accept && !drain) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (drain && !accept) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign OCC = occ_q;

    always_ff @(posedge CLK) begin
        if (RST_N) begin
            occ_bound: assert (occ_q <= OCC_W'(DEPTH));
        end
    end

endmodule

// File: tb/tb_not_pipe.sv
// Directed bench for not_pipe (WIDTH=8, DEPTH=2); parity checks when NOT_PIPE_PARITY_EN is defined.
module tb_not_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] MASK;
    logic             A_VALID;
    logic             A_READY;
    logic [WIDTH-1:0] Y;
    logic             Y_VALID;
    logic             Y_READY;
    logic [1:0]       OCC;
`ifdef NOT_PIPE_PARITY_EN
    logic             Y_PAR;
`endif

    int total = 0;
    int bad   = 0;

    not_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .A       (A),
        .MASK    (MASK),
        .A_VALID (A_VALID),
        .A_READY (A_READY),
        .Y       (Y),
        .Y_VALID (Y_VALID),
        .Y_READY (Y_READY),
`ifdef NOT_PIPE_PARITY_EN
        .Y_PAR   (Y_PAR),
`endif
        .OCC     (OCC)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] m);
        A_VALID = v;
        A       = a;
        MASK    = m;
    endtask

    initial begin
        RST_N   = 1'b0;
        Y_READY = 1'b1;
        drive(1'b0, 8'h00, 8'h00);
        #12;
        check("rst_yvalid", {31'd0, Y_VALID}, 32'd0);
        check("rst_y", {24'd0, Y}, 32'h00);
        check("rst_occ", {30'd0, OCC}, 32'd0);
        RST_N = 1'b1;
        #2;
        check("rst_aready", {31'd0, A_READY}, 32'd1);

        // Single beat, full invert: latency 2, OCC 1,1,0.
        drive(1'b1, 8'h5A, 8'hFF);
        tick();
        drive(1'b0, 8'h00, 8'h00);
        check("t1_occ_c1", {30'd0, OCC}, 32'd1);
        check("t1_yvalid_c1", {31'd0, Y_VALID}, 32'd0);
        tick();
        check("t1_yvalid_c2", {31'd0, Y_VALID}, 32'd1);
        check("t1_y_c2", {24'd0, Y}, 32'hA5);
        check("t1_occ_c2", {30'd0, OCC}, 32'd1);
        tick();
        check("t1_occ_c3", {30'd0, OCC}, 32'd0);
        check("t1_yvalid_c3", {31'd0, Y_VALID}, 32'd0);

        // Back-to-back partial masks.
        drive(1'b1, 8'h5A, 8'h0F);
        check("t2_aready_b0", {31'd0, A_READY}, 32'd1);
        tick();
        drive(1'b1, 8'h3C, 8'h00);
        check("t2_aready_b1", {31'd0, A_READY}, 32'd1);
        tick();
        drive(1'b0, 8'h00, 8'h00);
        check("t2_y0", {24'd0, Y}, 32'h55);
        check("t2_yvalid0", {31'd0, Y_VALID}, 32'd1);
        check("t2_occ_mid", {30'd0, OCC}, 32'd2);
        tick();
        check("t2_y1", {24'd0, Y}, 32'h3C);
        check("t2_yvalid1", {31'd0, Y_VALID}, 32'd1);
        tick();
        check("t2_occ_end", {30'd0, OCC}, 32'd0);

        // Stall, fill, then full accept-and-drain and in-order release.
        Y_READY = 1'b0;
        drive(1'b1, 8'h01, 8'hFF);
        tick();
        drive(1'b1, 8'h02, 8'hFF);
        check("t3_aready_1", {31'd0, A_READY}, 32'd1);
        tick();
        drive(1'b1, 8'h03, 8'hFF);
        check("t3_occ_full", {30'd0, OCC}, 32'd2);
        check("t3_aready_full", {31'd0, A_READY}, 32'd0);
        check("t3_y_hold0", {24'd0, Y}, 32'hFE);
        tick();
        check("t3_y_hold1", {24'd0, Y}, 32'hFE);
        check("t3_yvalid_hold", {31'd0, Y_VALID}, 32'd1);
        check("t3_occ_hold", {30'd0, OCC}, 32'd2);
        Y_READY = 1'b1;
        #1;
        check("t4_aready_full_rdy", {31'd0, A_READY}, 32'd1);
        tick();
        drive(1'b0, 8'h00, 8'h00);
        check("t4_occ_same", {30'd0, OCC}, 32'd2);
        check("t3_y_out1", {24'd0, Y}, 32'hFD);
        tick();
        check("t3_y_out2", {24'd0, Y}, 32'hFC);
        check("t3_occ_out2", {30'd0, OCC}, 32'd1);
        tick();
        check("t3_occ_empty", {30'd0, OCC}, 32'd0);
        check("t3_yvalid_empty", {31'd0, Y_VALID}, 32'd0);

        // Asynchronous reset with two beats in flight.
        Y_READY = 1'b0;
        drive(1'b1, 8'h11, 8'h00);
        tick();
        drive(1'b1, 8'h22, 8'h00);
        tick();
        drive(1'b0, 8'h00, 8'h00);
        check("t5_occ_pre", {30'd0, OCC}, 32'd2);
        #2;
        RST_N = 1'b0;
        #1;
        check("t5_occ_rst", {30'd0, OCC}, 32'd0);
        check("t5_yvalid_rst", {31'd0, Y_VALID}, 32'd0);
        check("t5_y_rst", {24'd0, Y}, 32'h00);
        #1;
        RST_N   = 1'b1;
        Y_READY = 1'b1;
        tick();
        drive(1'b1, 8'hC3, 8'hF0);
        tick();
        drive(1'b0, 8'h00, 8'h00);
        check("t5_yvalid_lat1", {31'd0, Y_VALID}, 32'd0);
        tick();
        check("t5_yvalid_lat2", {31'd0, Y_VALID}, 32'd1);
        check("t5_y_lat2", {24'd0, Y}, 32'h33);
        tick();

`ifdef NOT_PIPE_PARITY_EN
        drive(1'b1, 8'h07, 8'h00);
        tick();
        drive(1'b1, 8'h03, 8'h00);
        tick();
        drive(1'b0, 8'h00, 8'h00);
        check("t6_y_p1", {24'd0, Y}, 32'h07);
        check("t6_par_p1", {31'd0, Y_PAR}, 32'd1);
        tick();
        check("t6_y_p0", {24'd0, Y}, 32'h03);
        check("t6_par_p0", {31'd0, Y_PAR}, 32'd0);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/not_pipe.md
Name: not_pipe

Overview:
- Parametrised, pipelined successor to the single-bit NOT gate.
- Inverts a WIDTH-bit word under a per-beat bit mask, so Y = A ^ MASK; MASK all-ones gives a plain NOT.
- Carries data through DEPTH register stages with a valid/ready handshake.
- Used as a sequential test primitive for v2x pipeline and packing flows.

Parameters:
- WIDTH, 8: data and mask width in bits; legal range is 1 or more.
- DEPTH, 2: number of register stages; legal range is 1 to 16. DEPTH=0 is illegal and must fail elaboration.

Ports:
- CLK  input  1  sole clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- A  input  WIDTH  input data word.
- MASK  input  WIDTH  per-bit invert mask, sampled together with A.
- A_VALID  input  1  input beat valid.
- A_READY  output  1  input beat accepted when A_VALID and A_READY are both high.
- Y  output  WIDTH  result word, equal to A ^ MASK of the oldest beat.
- Y_VALID  output  1  Y holds a valid beat.
- Y_READY  input  1  downstream accepts Y.
- OCC  output  $clog2(DEPTH+1)  number of beats currently held.

Behaviour:
- Reset (RST_N low, asynchronous): all stage valid bits clear, all stage data registers clear, Y=0, Y_VALID=0, OCC=0. A_READY=1 once reset is released.
- Reset mid-operation: every beat in flight is dropped with no output. The first edge after release behaves as from empty.
- Compute: the XOR is done combinationally at the input. Stage 0 registers A ^ MASK. Stages 1..DEPTH-1 shift the word unchanged. Y and Y_VALID come directly from the last stage.
- Stage i load condition: load_i = !valid_i || load_(i+1). For the last stage, load = !valid_last || Y_READY.
- A_READY = load_0, a combinational ready chain; there is no skid buffer.
- Stage i takes valid_(i-1) and data_(i-1) when load_i. Stage 0 takes A_VALID and A^MASK.
- Stages are not "bubble-collapsing only": an empty stage always loads, so bubbles collapse.
- Latency: an accepted beat appears on Y exactly DEPTH cycles after acceptance if no stall occurs.
- Throughput: one beat per cycle when Y_READY is held high.
- Stall: while Y_VALID=1 and Y_READY=0:
  - Y is held stable.
  - Upstream stages keep filling until all DEPTH stages are valid; A_READY then drops to 0.
- Full: OCC=DEPTH and Y_READY=0 gives A_READY=0.
  - Full with Y_READY=1: A_READY=1, and accept and drain happen in the same cycle.
- Empty: OCC=0 gives Y_VALID=0. Y keeps its last value; the bench must not check Y when Y_VALID=0.
- OCC update:
  - +1 on accept only.
  - -1 on drain only (Y_VALID and Y_READY).
  - Unchanged when both or neither occur.
  - Never wraps; an assertion fires if OCC exceeds DEPTH.
- A and MASK are don't-care when A_VALID=0. An X value on them must not reach a valid stage.

Optional Feature:
- Macro: NOT_PIPE_PARITY_EN.
- Defined:
  - Adds output port Y_PAR (1 bit). It equals the even parity of the stage-0 result (^(A^MASK)), computed at stage 0 and carried through every stage with its word.
  - Y_PAR resets to 0 and is valid only with Y_VALID.
- Undefined:
  - The port and its registers do not exist.
  - All other behaviour is identical.

Decomposition:
- Package not_pipe_pkg holds:
  - the DEPTH_MAX=16 constant;
  - function occ_w(depth) returning $clog2(depth+1);
  - typedef stage_t, a struct of valid, data[WIDTH] and the optional parity bit, parametrised through a localparam wrapper.
- Sub-module not_pipe_stage holds one register slice with valid, data and optional parity. Its inputs are in_valid, in_data and load; its outputs are valid and data. It resets asynchronously and is instantiated DEPTH times with a generate loop.
- The top level holds the XOR, the ready chain and the OCC counter.

Test Plan:
- WIDTH=8, DEPTH=2, Y_READY=1; send A=0x5A with MASK=0xFF at cycle 0 -> Y=0xA5 and Y_VALID=1 at cycle 2; OCC goes 1,1,0.
- Send MASK=0x0F with A=0x5A, then MASK=0x00 with A=0x3C, back-to-back -> Y=0x55 then Y=0x3C on consecutive cycles, with A_READY held at 1.
- Y_READY=0; push 3 beats (0x01, 0x02, 0x03) with MASK=0xFF -> after 2 accepts OCC=2 and A_READY=0, Y=0xFE held stable. Raise Y_READY -> outputs 0xFE, 0xFD, 0xFC in order with no loss or duplication.
- Full pipe with A_VALID=1 and Y_READY=1 in the same cycle -> accept and drain together, OCC stays 2.
- Assert RST_N=0 asynchronously mid-stream with OCC=2 -> Y_VALID=0, Y=0 and OCC=0 immediately without a clock edge; after release the next beat again has 2-cycle latency.
- With NOT_PIPE_PARITY_EN defined, A=0x07 and MASK=0x00 -> Y_PAR=1 arrives with Y=0x07. A=0x03 -> Y_PAR=0.
